// File: rtl/otter_muldiv_pkg.sv
// Shared types for the OTTER RV32M multiply/divide unit.
package otter_muldiv_pkg;

  // Encoded identically to funct3 so the decoder field can be cast directly.
  typedef enum logic [2:0] {
    MUL    = 3'b000,
    MULH   = 3'b001,
    MULHSU = 3'b010,
    MULHU  = 3'b011,
    DIV    = 3'b100,
    DIVU   = 3'b101,
    REM    = 3'b110,
    REMU   = 3'b111
  } md_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } md_state_t;

  localparam logic [6:0] MD_FUNCT7 = 7'b0000001;

endpackage

// File: rtl/otter_muldiv_unit.sv
// Iterative RV32M multiply/divide unit for the OTTER EX stage.
// One shared 2*WIDTH shift register carries product (mul) or {remainder, quotient} (div),
// stepped by a single WIDTH+1 adder/subtractor, one radix-2 step per cycle.
module otter_muldiv_unit
  import otter_muldiv_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             MulDivStartE,
  input  logic [2:0]       Funct3E,
  input  logic [WIDTH-1:0] SrcAE,
  input  logic [WIDTH-1:0] SrcBE,
  input  logic             FlushE,
  output logic             StallMD,
  output logic             ResultValid,
  output logic [WIDTH-1:0] ResultMD
);

  localparam int unsigned CntW = $clog2(WIDTH) + 1;
  localparam int unsigned W2   = 2 * WIDTH;

  md_state_t         state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  md_op_t            op_q, op_d;
  logic              neg_q, neg_d;    // product / quotient sign
  logic              rneg_q, rneg_d;  // remainder sign
  logic [W2-1:0]     acc_q, acc_d;
  logic [WIDTH-1:0]  b_q, b_d;
  logic [WIDTH-1:0]  res_q, res_d;
  logic              valid_q, valid_d;

  // Start-time operand decode
  md_op_t           start_op;
  logic             a_signed, b_signed, sa, sb, div_zero, div_ovf;
  logic [WIDTH-1:0] a_mag, b_mag;

  // Iteration datapath
  logic [WIDTH:0]   step_a, step_sum;
  logic [W2-1:0]    step_acc, prod_fin;
  logic [WIDTH-1:0] quot_fin, rem_fin, fin_res;

  // Operand sign handling and special-case detection for a start in IDLE
  always_comb begin
    start_op = md_op_t'(Funct3E);
    a_signed = (start_op == MULH) || (start_op == MULHSU) || (start_op == DIV) ||
               (start_op == REM);
    b_signed = (start_op == MULH) || (start_op == DIV) || (start_op == REM);
    sa       = a_signed & SrcAE[WIDTH-1];
    sb       = b_signed & SrcBE[WIDTH-1];
    a_mag    = sa ? -SrcAE : SrcAE;
    b_mag    = sb ? -SrcBE : SrcBE;
    div_zero = Funct3E[2] && (SrcBE == '0);
    div_ovf  = ((start_op == DIV) || (start_op == REM)) &&
               (SrcAE == {1'b1, {(WIDTH-1){1'b0}}}) && (&SrcBE);
  end

  // One shift-add (mul) or restoring shift-subtract (div) step, plus final sign fix-up
  always_comb begin
    step_a   = op_q[2] ? {acc_q[W2-1:WIDTH], acc_q[WIDTH-1]} : {1'b0, acc_q[W2-1:WIDTH]};
    step_sum = op_q[2] ? (step_a - {1'b0, b_q}) : (step_a + {1'b0, b_q});
    if (op_q[2]) begin
      // Borrow means the shifted remainder was smaller than the divisor: restore it.
      step_acc = step_sum[WIDTH] ? {step_a[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0}
                                 : {step_sum[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
    end else begin
      step_acc = acc_q[0] ? {step_sum, acc_q[WIDTH-1:1]} : {1'b0, acc_q[W2-1:1]};
    end
    prod_fin = neg_q ? -step_acc : step_acc;
    quot_fin = neg_q ? -step_acc[WIDTH-1:0] : step_acc[WIDTH-1:0];
    rem_fin  = rneg_q ? -step_acc[W2-1:WIDTH] : step_acc[W2-1:WIDTH];
    case (op_q)
      MUL:                  fin_res = prod_fin[WIDTH-1:0];
      MULH, MULHSU, MULHU:  fin_res = prod_fin[W2-1:WIDTH];
      DIV, DIVU:            fin_res = quot_fin;
      default:              fin_res = rem_fin;
    endcase
  end

  // Next-state, stall and result-load control
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    neg_d   = neg_q;
    rneg_d  = rneg_q;
    acc_d   = acc_q;
    b_d     = b_q;
    res_d   = res_q;
    valid_d = 1'b0;
    StallMD = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (MulDivStartE && !FlushE) begin
          StallMD = 1'b1;
          op_d    = start_op;
          neg_d   = sa ^ sb;
          rneg_d  = sa;
          b_d     = b_mag;
          cnt_d   = '0;
          if (div_zero) begin
            res_d   = Funct3E[1] ? SrcAE : '1;
            valid_d = 1'b1;
            state_d = DONE;
          end else if (div_ovf) begin
            res_d   = Funct3E[1] ? '0 : SrcAE;
            valid_d = 1'b1;
            state_d = DONE;
          end else begin
            acc_d   = {{WIDTH{1'b0}}, a_mag};
            state_d = CALC;
          end
        end
      end
      CALC: begin
        StallMD = 1'b1;
        if (FlushE) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          acc_d = step_acc;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CntW'(WIDTH - 1)) begin
            res_d   = fin_res;
            valid_d = 1'b1;
            cnt_d   = '0;
            state_d = DONE;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      op_q    <= MUL;
      neg_q   <= 1'b0;
      rneg_q  <= 1'b0;
      acc_q   <= '0;
      b_q     <= '0;
      res_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      neg_q   <= neg_d;
      rneg_q  <= rneg_d;
      acc_q   <= acc_d;
      b_q     <= b_d;
      res_q   <= res_d;
      valid_q <= valid_d;
    end
  end

  assign ResultValid = valid_q;
  assign ResultMD    = res_q;

endmodule
